// File: rtl/core_pkg.sv
// core_pkg: shared widths, reset PC, fetch step and fetch FSM state type.
package core_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INST_W = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int DEF_PC_STEP = 4;
    typedef enum logic [1:0] {RUN, BUBBLE, HALT} fetch_state_t;
endpackage

// File: rtl/out_buf_reg.sv
// out_buf_reg: one-entry valid/ready register holding {pc, inst}, flush has priority.
module out_buf_reg #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o
);
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_q;
    logic [INST_W-1:0] inst_q;
    always_comb valid_d = flush_i ? 1'b0 : load_i ? 1'b1 : valid_q && !ready_i;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else begin
            valid_q <= valid_d;
            if (load_i && !flush_i) begin
                pc_q   <= pc_i;
                inst_q <= inst_i;
            end
        end
    end
    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the PC, issues req/ack memory fetches and buffers words toward Fetch.
module pc_fetch_unit import core_pkg::*; #(
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter int          INST_W   = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int          PC_STEP  = DEF_PC_STEP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic              halted,
    output logic [15:0]       fetch_count
);
    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       count_q;
    logic              redirect, misaligned, accept, drain;
    assign redirect   = redirect_valid && state_q != HALT;
    assign misaligned = (redirect_pc & ADDR_W'(PC_STEP - 1)) != '0;
    assign accept     = mem_req && mem_ack;
    assign drain      = out_valid && out_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end
    always_comb state_d = redirect ? (misaligned ? HALT : BUBBLE) : (state_q == BUBBLE ? RUN : state_q);
    // Request is withdrawn combinationally so reset or a redirect never leaves a stale request.
    always_comb begin
        mem_req = !rst && state_q == RUN && !redirect_valid && (!out_valid || out_ready);
        halted  = state_q == HALT;
    end
    always_comb pc_d = redirect ? redirect_pc : accept ? pc_q + ADDR_W'(PC_STEP) : pc_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_q + 16'(drain);
        end
    end
    assign mem_addr    = pc_q;
    assign fetch_count = count_q;
    out_buf_reg #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_out_buf (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .load_i  (accept),
        .pc_i    (pc_q),
        .inst_i  (mem_rdata),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .pc_o    (out_pc),
        .inst_o  (out_inst)
    );
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: randomized scoreboard bench with a behavioural fetch model.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        halted;
    logic [15:0] fetch_count;

    pc_fetch_unit dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc = '0;
    logic        m_halt = 1'b0;
    logic        m_bubble = 1'b0;
    logic [15:0] m_count = '0;
    logic        exp_req = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: a word is queued when the model decides a fetch is accepted; redirects empty the queue.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_pc = 32'h0;
            m_halt = 1'b0;
            m_bubble = 1'b0;
            m_count = '0;
        end else if (!m_halt) begin
            if (redirect_valid) begin
                q.delete();
                m_pc = redirect_pc;
                if (redirect_pc % 4 != 0) m_halt = 1'b1;
                else m_bubble = 1'b1;
            end else begin
                m_bubble = 1'b0;
                if (exp_req && mem_ack) begin
                    q.push_back('{pc: m_pc, inst: mem_rdata});
                    m_pc = m_pc + 4;
                end
            end
        end
    end

    // Monitor: compares visible state away from the edge and pops delivered words.
    always @(negedge clk) begin
        ent_t e;
        exp_req = !rst && !m_halt && !m_bubble && !redirect_valid && (q.size() == 0 || out_ready);
        check("mem_req", 32'(mem_req), 32'(exp_req));
        check("mem_addr", mem_addr, m_pc);
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("halted", 32'(halted), 32'(m_halt));
        check("fetch_count", 32'(fetch_count), 32'(m_count));
        if (rst) begin
            check("rst_out_pc", out_pc, 32'h0);
            check("rst_out_inst", out_inst, 32'h0);
        end
        if (q.size() != 0 && out_ready) begin
            e = q.pop_front();
            check("out_pc", out_pc, e.pc);
            check("out_inst", out_inst, e.inst);
            m_count = m_count + 16'd1;
        end
    end

    task automatic step(input logic rv, input logic [31:0] rpc, input logic ack, input logic rdy);
        redirect_valid = rv;
        redirect_pc = rpc;
        mem_ack = ack;
        out_ready = rdy;
        mem_rdata = $urandom;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        rv;
        logic [31:0] tgt;
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1);
        rst = 1'b0;
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);
        repeat (5) step(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h100, 1'b1, 1'b1);
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h200, 1'b1, 1'b1);
        step(1'b1, 32'h300, 1'b1, 1'b1);
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'h102, 1'b1, 1'b1);
        repeat (5) step($urandom_range(0, 1) == 1, 32'h400, 1'b1, 1'b1);
        rst = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        rst = 1'b0;
        repeat (3) step(1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 400; i++) begin
            if (m_halt) begin
                rst = 1'b1;
                step(1'b0, 32'h0, 1'b0, 1'b1);
                rst = 1'b0;
            end else begin
                rv = $urandom_range(0, 15) == 0;
                tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
                if ($urandom_range(0, 7) == 0) tgt = tgt | 32'($urandom_range(1, 3));
                step(rv, tgt, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            end
        end
        rst = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b1);
        rst = 1'b0;
        repeat (65540) step(1'b0, 32'h0, 1'b1, 1'b1);
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Upstream neighbour of the Fetch stage. Owns the program counter and issues instruction-memory requests with a req/ack handshake. Holds each returned word plus its PC in a one-entry output register with a valid/ready handshake toward Fetch. Handles branch/jump redirects: in-flight and buffered words are squashed, and a misaligned target halts the unit.

Parameters:
ADDR_W, 32, PC and memory address width
INST_W, 32, instruction word width
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
redirect_valid  in  1  branch/jump override from a later stage
redirect_pc  in  ADDR_W  redirect target
mem_req  out  1  instruction memory request
mem_addr  out  ADDR_W  request address (= pc_q)
mem_ack  in  1  memory returns mem_rdata this cycle; only meaningful while mem_req=1
mem_rdata  in  INST_W  returned instruction word
out_valid  out  1  output register holds a valid instruction
out_ready  in  1  Fetch accepts the output this cycle
out_pc  out  ADDR_W  PC of the buffered instruction
out_inst  out  INST_W  buffered instruction word
halted  out  1  unit stopped on a misaligned redirect
fetch_count  out  16  instructions delivered to Fetch, wraps at 2^16

Behaviour:
- Reset (async, immediate): pc_q=RESET_PC, state=RUN, out_valid=0, out_pc=0, out_inst=0, halted=0, fetch_count=0, mem_req=0.
- States: RUN, BUBBLE, HALT.
- mem_req = (state==RUN) && !redirect_valid && (!out_valid || out_ready). The output is combinational from registered state and the redirect/ready inputs.
- mem_addr = pc_q at all times.
- Accept: mem_req && mem_ack. On the next edge: out_inst<=mem_rdata, out_pc<=pc_q, out_valid<=1, pc_q<=pc_q+PC_STEP.
  - Addition is ADDR_W-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0, with no flag.
- Sustained throughput: 1 instruction/cycle while mem_ack=1 and out_ready=1 (accept and drain in the same cycle).
- Drain: out_valid && out_ready increments fetch_count. If no accept happens in that cycle, out_valid<=0.
- Backpressure: out_valid && !out_ready holds out_pc, out_inst and pc_q stable, and mem_req=0.
- Memory latency: mem_req stays high with mem_addr stable until mem_ack. Any number of wait cycles is allowed.
- Redirect (any state except HALT, highest priority):
  - out_valid<=0 (buffered word discarded, not counted).
  - A mem_ack in the same cycle is ignored.
  - pc_q<=redirect_pc; state<=BUBBLE.
  - Redirect and out_ready in the same cycle: the word still counts as delivered, because Fetch already took it.
- BUBBLE: mem_req=0 for exactly one cycle, then RUN. A new redirect during BUBBLE overrides pc_q and stays in BUBBLE.
- Misaligned redirect (redirect_pc[1:0]!=0 when PC_STEP=4): state<=HALT, halted<=1, pc_q<=redirect_pc, out_valid<=0.
- HALT: mem_req=0 and all inputs are ignored; only rst exits.
- Reset asserted mid-handshake: the request is dropped. Memory must tolerate a req withdrawn without ack.
- fetch_count wraps 16'hFFFF -> 0.

Decomposition:
- Shared package core_pkg:
  - ADDR_W/INST_W defaults
  - RESET_PC
  - PC_STEP
  - typedef enum logic [1:0] {RUN, BUBBLE, HALT} fetch_state_t
- One sub-module, out_buf_reg: the one-entry valid/ready register holding {pc, inst}, with a flush input. The FSM, PC and counter stay in the top module.

Test Plan:
- Reset, then mem_ack=1 with mem_rdata=addr^32'hA5A5_A5A5 and out_ready=1 -> mem_addr sequence 0,4,8,C. out_pc 0,4,8 on consecutive cycles starting the cycle after the first ack. fetch_count=3 after three drains.
- out_ready=0 for 5 cycles after the first accept -> out_valid=1, out_pc=0 and mem_req=0 held for all 5 cycles. Release -> next address 4 requested in the same cycle as the drain.
- mem_ack delayed 3 cycles at addr 8 -> mem_req=1 and mem_addr=8 held stable for 4 cycles, then out_pc=8.
- redirect_valid with redirect_pc=0x100 in the same cycle as mem_ack at addr 0xC -> 0xC never appears on out_pc. One cycle with mem_req=0, then mem_addr=0x100. fetch_count excludes 0xC.
- redirect_pc=0x102 -> halted=1 next edge, mem_req=0 forever, out_valid=0. rst then resumes fetching at RESET_PC.
- redirect_pc=0xFFFF_FFFC, acks continue -> mem_addr wraps to 0x0. Also preload fetch_count near 16'hFFFF by 65536 drains (or a force) -> wraps to 0.
